// File: rtl/rvx_reset_conditioner.sv
`timescale 1ns/1ps
// Board reset conditioner: synchronises and debounces the push-button, then stretches the SoC reset.
// Latency: 2 sync edges + DEBOUNCE_CYCLES to assert, release debounce + RESET_HOLD_CYCLES to deassert.
// Backpressure: none; the button is sampled every cycle and all outputs come straight from flops.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      board-level reset (e.g. PLL lock), synchronous, active-low
//   button       raw asynchronous push-button pin
//   soc_reset_n  conditioned SoC reset, active-low, registered
//   button_level debounced pressed level (1 = pressed, after polarity normalisation)
//   reset_event  one-cycle pulse on the edge that starts a button reset
module rvx_reset_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int RESET_HOLD_CYCLES  = 1024,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic soc_reset_n,
    output logic button_level,
    output logic reset_event
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    localparam logic [2:0] ST_HOLD         = 3'd0;
    localparam logic [2:0] ST_RUN          = 3'd1;
    localparam logic [2:0] ST_PRESS_QUAL   = 3'd2;
    localparam logic [2:0] ST_PRESSED      = 3'd3;
    localparam logic [2:0] ST_RELEASE_QUAL = 3'd4;

    logic          sync_q1;
    logic          pressed_sync;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          state_change;

    // Polarity is normalised before the first flop so everything downstream
    // works in "pressed = 1" terms.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q1      <= 1'b0;
            pressed_sync <= 1'b0;
        end else begin
            sync_q1      <= button ^ ~BUTTON_ACTIVE_HIGH;
            pressed_sync <= sync_q1;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            ST_RUN: begin
                if (pressed_sync) begin
                    state_nxt = ST_PRESS_QUAL;
                end
            end
            ST_PRESS_QUAL: begin
                if (!pressed_sync) begin
                    state_nxt = ST_RUN;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_PRESSED;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            ST_PRESSED: begin
                if (!pressed_sync) begin
                    state_nxt = ST_RELEASE_QUAL;
                end
            end
            ST_RELEASE_QUAL: begin
                if (pressed_sync) begin
                    state_nxt = ST_PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_HOLD;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

    // Both counters restart from zero whenever the FSM enters a new state,
    // so a bounce always forces a full re-qualification.
    assign state_change = (state_nxt != state);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_HOLD;
            deb_cnt      <= '0;
            hold_cnt     <= '0;
            soc_reset_n  <= 1'b0;
            button_level <= 1'b0;
            reset_event  <= 1'b0;
        end else begin
            state        <= state_nxt;
            deb_cnt      <= state_change ? '0 : deb_nxt;
            hold_cnt     <= state_change ? '0 : hold_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the transition that causes them.
            soc_reset_n  <= (state_nxt == ST_RUN) || (state_nxt == ST_PRESS_QUAL);
            button_level <= (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_QUAL);
            reset_event  <= (state == ST_PRESS_QUAL) && (state_nxt == ST_PRESSED);
        end
    end

endmodule

// File: tb/tb_rvx_reset_conditioner.sv
`timescale 1ns/1ps
// Bench for rvx_reset_conditioner with DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8.
// Expected output values are queued with the edge at which they must appear;
// the monitor pops an entry whenever an output changes or an entry falls due.
module tb_rvx_reset_conditioner;

    logic clock;
    logic reset_n;
    logic button;
    logic soc_reset_n;
    logic button_level;
    logic reset_event;

    rvx_reset_conditioner #(
        .DEBOUNCE_CYCLES   (4),
        .RESET_HOLD_CYCLES (8),
        .BUTTON_ACTIVE_HIGH(1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .button      (button),
        .soc_reset_n (soc_reset_n),
        .button_level(button_level),
        .reset_event (reset_event)
    );

    typedef struct {
        int         edge_no;
        logic [2:0] val;   // {soc_reset_n, button_level, reset_event}
    } exp_t;

    exp_t       exp_q[$];
    int         edge_n  = 0;
    int         n_check = 0;
    int         n_pass  = 0;
    bit         mon_en  = 1'b0;
    logic [2:0] prev    = 3'b000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    function automatic void push(input int e, input logic [2:0] v);
        exp_t x;
        x.edge_no = e;
        x.val     = v;
        exp_q.push_back(x);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: any output change must match the head of the queue, and any
    // entry that has fallen due is compared even without a change.
    always @(negedge clock) begin
        logic [2:0] cur;
        bit         due;
        exp_t       e;
        if (mon_en) begin
            cur = {soc_reset_n, button_level, reset_event};
            due = 1'b0;
            if (exp_q.size() > 0) begin
                if (exp_q[0].edge_no <= edge_n) due = 1'b1;
            end
            if ((cur !== prev) || due) begin
                n_check++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: edge %0d soc/lvl/evt=%b, none expected", edge_n, cur);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.edge_no != edge_n) || (cur !== e.val)) begin
                        $display("FAIL outputs: got edge %0d soc/lvl/evt=%b, want edge %0d soc/lvl/evt=%b",
                                 edge_n, cur, e.edge_no, e.val);
                    end else begin
                        n_pass++;
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, t, k, l, r;
        reset_n = 1'b0;
        button  = 1'b0;
        tick(3);
        mon_en = 1'b1;

        // Power-on: edge b is the last edge with reset_n low.
        b = edge_n;
        reset_n = 1'b1;
        push(b,     3'b000);
        push(b + 7, 3'b000);
        push(b + 8, 3'b100);

        // Clean press before edge b+20, release before edge b+40.
        tick(19);
        button = 1'b1;
        push(b + 25, 3'b100);
        push(b + 26, 3'b011);
        push(b + 27, 3'b010);
        tick(20);
        button = 1'b0;
        push(b + 46, 3'b000);
        push(b + 53, 3'b000);
        push(b + 54, 3'b100);
        tick(21);

        // Press bounce: 3 high / 1 low, five times; never qualifies.
        for (int i = 0; i < 5; i++) begin
            button = 1'b1;
            tick(3);
            button = 1'b0;
            tick(1);
        end
        tick(6);
        push(edge_n, 3'b100);
        tick(2);

        // Release bounce: press, then low 2 / high 1 three times, then steady low.
        t = edge_n;
        button = 1'b1;
        push(t + 7, 3'b011);
        push(t + 8, 3'b010);
        tick(10);
        for (int i = 0; i < 3; i++) begin
            button = 1'b0;
            tick(2);
            button = 1'b1;
            tick(1);
        end
        button = 1'b0;
        l = edge_n + 1;
        push(l + 6,  3'b000);
        push(l + 13, 3'b000);
        push(l + 14, 3'b100);
        tick(20);

        // reset_n asserted while PRESS_QUAL has deb_cnt=2.
        t = edge_n;
        k = t + 1;
        button = 1'b1;
        tick(5);
        reset_n = 1'b0;
        button  = 1'b0;
        push(k + 5, 3'b000);
        tick(1);
        reset_n = 1'b1;
        push(k + 12, 3'b000);
        push(k + 13, 3'b100);
        tick(14);

        // Button held across reset and HOLD.
        t = edge_n;
        reset_n = 1'b0;
        button  = 1'b1;
        push(t + 1, 3'b000);
        tick(3);
        r = edge_n;
        reset_n = 1'b1;
        push(r + 7,  3'b000);
        push(r + 8,  3'b100);
        push(r + 13, 3'b011);
        push(r + 14, 3'b010);
        tick(14);
        button = 1'b0;
        l = edge_n + 1;
        push(l + 6,  3'b000);
        push(l + 14, 3'b100);
        tick(20);

        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_check++;
            $display("FAIL never_seen: expected edge %0d soc/lvl/evt=%b not observed", e.edge_no, e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
